// File: rtl/uart_pkg.sv
// Shared UART definitions: front-end state encoding, frame size default and
// the bit-period helper used by both the front end and the byte receiver.
package uart_pkg;

    localparam int FRAME_BITS_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BITS  = 2'd2;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_front_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to a
// configurable level so an idle-high line does not look like an edge.
module sync_ff #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_front.sv
// UART receive front end: synchronises RX, finds the start edge and issues
// one mid-bit center_tick per start, data and stop bit.
module uart_rx_front
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_sync_out,
    output logic center_tick,
    output logic busy,
    output logic glitch
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(FRAME_BITS + 3);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] STOP_IDX  = BIT_W'(FRAME_BITS + 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx_front: CLKS_PER_BIT must be at least 4");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             prev;
    logic             fall;
    logic             half_done;
    logic             bit_done;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_sync_out)
    );

    // Edge detection runs in every state so a start edge coinciding with the
    // stop tick is not lost.
    assign fall      = prev & ~rx_sync_out;
    assign half_done = (state == ST_START) && (baud_cnt == HALF_LAST);
    assign bit_done  = (state == ST_BITS)  && (baud_cnt == BIT_LAST);

    assign center_tick = (half_done && !rx_sync_out) || bit_done;
    assign glitch      = half_done && rx_sync_out;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            prev     <= 1'b1;
        end else begin
            prev <= rx_sync_out;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_done) begin
                        baud_cnt <= '0;
                        if (!rx_sync_out) begin
                            state   <= ST_BITS;
                            bit_cnt <= BIT_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_BITS: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_IDX) begin
                            bit_cnt <= '0;
                            state   <= fall ? ST_START : ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_front.sv
// Directed bench for uart_rx_front at 10 clks/bit: tick timing, sampled
// values, glitch rejection, back-to-back frames, async reset and break.
module tb_uart_rx_front;

    logic clk = 1'b0;
    logic reset;
    logic rx_in;
    logic rx_sync_out;
    logic center_tick;
    logic busy;
    logic glitch;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_high = 0;

    int   tick_cyc[$];
    logic tick_val[$];
    int   glitch_cyc[$];
    logic busy_hist[4096];

    uart_rx_front #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .FRAME_BITS  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_sync_out (rx_sync_out),
        .center_tick (center_tick),
        .busy        (busy),
        .glitch      (glitch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record observations mid-cycle, indexed by the number of rising edges so far.
    always @(negedge clk) begin
        busy_hist[cyc % 4096] <= busy;
        if (center_tick) begin
            tick_cyc.push_back(cyc);
            tick_val.push_back(rx_sync_out);
        end
        if (glitch) glitch_cyc.push_back(cyc);
        if (center_tick && glitch) both_high <= both_high + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a falling edge; leaves the line high at the end.
    task automatic send_frame(input logic [7:0] data, output int start);
        logic [9:0] bits;
        bits  = {1'b1, data, 1'b0};
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_in = bits[i];
            repeat (10) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] decode(input int first);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tick_val[first + 1 + j];
        return b;
    endfunction

    // Tick k of a frame whose start bit was driven at cycle n lands at n+7+10k.
    task automatic check_frame(input string tag, input int first, input int n, input logic [7:0] data);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check_output({tag, "_cyc"}, tick_cyc[first + k], n + 7 + 10 * k);
            check_output({tag, "_bit"}, tick_val[first + k], bits[k]);
        end
        check_output({tag, "_byte"}, decode(first), data);
    endtask

    task automatic clear_logs();
        tick_cyc.delete();
        tick_val.delete();
        glitch_cyc.delete();
    endtask

    initial begin
        int n, n2, hits;
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_sync", rx_sync_out, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_tick", center_tick, 0);
        check_output("rst_glitch", glitch, 0);
        reset = 1'b0;

        // 1: idle line
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (center_tick || busy || glitch || !rx_sync_out) hits++;
        end
        check_output("idle_activity", hits, 0);
        check_output("idle_ticks", tick_cyc.size(), 0);

        // 2: single frame 0x55
        clear_logs();
        send_frame(8'h55, n);
        apply_idle(20);
        check_output("f55_count", tick_cyc.size(), 10);
        if (tick_cyc.size() == 10) check_frame("f55", 0, n, 8'h55);
        check_output("f55_busy_last", busy_hist[(n + 97) % 4096], 1);
        check_output("f55_busy_after", busy_hist[(n + 98) % 4096], 0);
        check_output("f55_glitch", glitch_cyc.size(), 0);

        // 3: two-clock low pulse is rejected at start center
        clear_logs();
        n = cyc;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        apply_idle(20);
        check_output("gl_count", glitch_cyc.size(), 1);
        if (glitch_cyc.size() == 1) check_output("gl_cyc", glitch_cyc[0], n + 7);
        check_output("gl_ticks", tick_cyc.size(), 0);
        check_output("gl_busy_at", busy_hist[(n + 7) % 4096], 1);
        check_output("gl_busy_after", busy_hist[(n + 8) % 4096], 0);

        // 4: back-to-back frames
        clear_logs();
        send_frame(8'hA3, n);
        send_frame(8'h0F, n2);
        apply_idle(20);
        check_output("b2b_count", tick_cyc.size(), 20);
        if (tick_cyc.size() == 20) begin
            check_frame("b2b_a3", 0, n, 8'hA3);
            check_frame("b2b_0f", 10, n2, 8'h0F);
        end
        check_output("b2b_glitch", glitch_cyc.size(), 0);

        // 5: async reset during data bit 3 of 0xC6
        clear_logs();
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0] ? 1'b1 : (i == 2);
            repeat (10) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        rx_in = 1'b1;
        #1;
        check_output("ar_busy", busy, 0);
        check_output("ar_tick", center_tick, 0);
        check_output("ar_sync", rx_sync_out, 1);
        @(negedge clk);
        reset = 1'b0;
        apply_idle(20);
        clear_logs();
        send_frame(8'hC6, n);
        apply_idle(20);
        check_output("ar_count", tick_cyc.size(), 10);
        if (tick_cyc.size() == 10) check_frame("ar_c6", 0, n, 8'hC6);

        // 6: break, then a fresh frame
        clear_logs();
        n = cyc;
        rx_in = 1'b0;
        repeat (300) @(negedge clk);
        apply_idle(50);
        check_output("brk_count", tick_cyc.size(), 10);
        if (tick_cyc.size() == 10) begin
            check_output("brk_last_cyc", tick_cyc[9], n + 97);
            check_output("brk_last_bit", tick_val[9], 0);
        end
        check_output("brk_glitch", glitch_cyc.size(), 0);
        send_frame(8'h5A, n2);
        apply_idle(20);
        check_output("brk_rearm_count", tick_cyc.size(), 20);
        if (tick_cyc.size() == 20) check_frame("brk_5a", 10, n2, 8'h5A);

        check_output("tick_glitch_overlap", both_high, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
